// File: rtl/vend_payment_unit_pkg.sv
// Shared definitions for the vending payment unit and its controller:
// controller state encodings, refund FSM encodings and the credit helper.
package vend_payment_unit_pkg;

  typedef enum logic [2:0] {
    ST_ZZZ           = 3'b000,
    ST_VALIDATE_ID   = 3'b001,
    ST_VALIDATE_COIN = 3'b010,
    ST_ALL_OK        = 3'b011,
    ST_ERROR1        = 3'b100,
    ST_ERROR2        = 3'b101
  } ctrl_state_e;

  typedef enum logic [1:0] {
    RF_IDLE     = 2'd0,
    RF_PULSE_HI = 2'd1,
    RF_PULSE_LO = 2'd2
  } refund_state_e;

  localparam logic [3:0] CREDIT_MAX = 4'd15;

  // Adds a coin to the credit, clamping at CREDIT_MAX instead of wrapping.
  function automatic logic [3:0] credit_add(input logic [3:0] credit, input logic [1:0] coin);
    logic [4:0] sum;
    sum = {1'b0, credit} + {3'b000, coin};
    return (sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : sum[3:0];
  endfunction

endpackage

// File: rtl/vend_payment_unit_if.sv
// Signal bundle between the vending controller / coin hardware (master)
// and the payment unit (slave).
interface vend_payment_unit_if;
  import vend_payment_unit_pkg::*;

  logic [2:0] state_now;
  logic       coin_in;
  logic [1:0] coin_val;
  logic       release_product;
  logic       back_money;
  logic [3:0] val_tot;
  logic       time_max_exb;
  logic       coin_out;
  logic       refund_busy;
  logic       vend_done;

  modport master (
    output state_now, coin_in, coin_val, release_product, back_money,
    input  val_tot, time_max_exb, coin_out, refund_busy, vend_done
  );

  modport slave (
    input  state_now, coin_in, coin_val, release_product, back_money,
    output val_tot, time_max_exb, coin_out, refund_busy, vend_done
  );

endinterface

// File: rtl/vend_payment_unit_exb_timer.sv
// Exhibition window timer: counts while enabled, restarts on request and
// emits a one-cycle pulse every TIME_CYCLES cycles.
module exb_timer #(
  parameter int TIME_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic time_max_exb
);

  localparam int            CW   = (TIME_CYCLES > 1) ? $clog2(TIME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIME_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;
  logic          pulse_q, pulse_d;

  // Next count: cleared while idle or on restart, wraps with a pulse at the end of a window.
  always_comb begin
    count_d = count_q;
    pulse_d = 1'b0;
    if (restart || !enable) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
      pulse_d = 1'b1;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter and registered pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  end

  assign time_max_exb = pulse_q;

endmodule

// File: rtl/vend_payment_unit.sv
// Payment side of the vending machine: accumulates coin credit, clears it
// on a sale, and pays it back as paced ejector pulses on refund.
module vend_payment_unit
  import vend_payment_unit_pkg::*;
#(
  parameter int TIME_CYCLES       = 50000000,
  parameter int COIN_PULSE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  vend_payment_unit_if.slave  bus
);

  localparam int            PW    = (COIN_PULSE_CYCLES > 1) ? $clog2(COIN_PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PLAST = PW'(COIN_PULSE_CYCLES - 1);

  logic          coin_q, release_q, back_q;
  logic [2:0]    state_q;
  logic          coin_rise, release_rise, back_rise, zzz_entry;
  refund_state_e rf_state_q, rf_state_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [3:0]    val_q, val_d;
  logic          vend_q, vend_d;
  logic          coin_out_q, busy_q;
  logic          refund_start;

  // The controller holds its request lines high, so only rising edges count.
  assign coin_rise    = bus.coin_in && !coin_q;
  assign release_rise = bus.release_product && !release_q;
  assign back_rise    = bus.back_money && !back_q;
  assign zzz_entry    = (bus.state_now == ST_ZZZ) && (state_q != ST_ZZZ);

  exb_timer #(
    .TIME_CYCLES(TIME_CYCLES)
  ) u_exb_timer (
    .clk         (clk),
    .rst         (rst),
    .enable      (bus.state_now != ST_ZZZ),
    .restart     (bus.state_now != state_q),
    .time_max_exb(bus.time_max_exb)
  );

  // Refund FSM plus credit update; coins and sales are only taken while idle.
  always_comb begin
    rf_state_d   = rf_state_q;
    pulse_cnt_d  = pulse_cnt_q;
    val_d        = val_q;
    vend_d       = 1'b0;
    refund_start = 1'b0;
    case (rf_state_q)
      RF_IDLE: begin
        if ((val_q != 4'd0) && (back_rise || zzz_entry)) begin
          refund_start = 1'b1;
          rf_state_d   = RF_PULSE_HI;
          pulse_cnt_d  = '0;
        end
        if (release_rise && !back_rise && !refund_start) begin
          val_d  = 4'd0;
          vend_d = 1'b1;
        end else if (coin_rise && (bus.state_now == ST_VALIDATE_COIN)) begin
          val_d = credit_add(val_q, bus.coin_val);
        end
      end
      RF_PULSE_HI: begin
        if (pulse_cnt_q == PLAST) begin
          rf_state_d  = RF_PULSE_LO;
          pulse_cnt_d = '0;
          val_d       = val_q - 4'd1;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      RF_PULSE_LO: begin
        if (pulse_cnt_q == PLAST) begin
          pulse_cnt_d = '0;
          rf_state_d  = (val_q != 4'd0) ? RF_PULSE_HI : RF_IDLE;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      default: rf_state_d = RF_IDLE;
    endcase
  end

  // Edge-detect copies, FSM state, credit and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin_q      <= 1'b0;
      release_q   <= 1'b0;
      back_q      <= 1'b0;
      state_q     <= 3'b000;
      rf_state_q  <= RF_IDLE;
      pulse_cnt_q <= '0;
      val_q       <= 4'd0;
      vend_q      <= 1'b0;
      coin_out_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      coin_q      <= bus.coin_in;
      release_q   <= bus.release_product;
      back_q      <= bus.back_money;
      state_q     <= bus.state_now;
      rf_state_q  <= rf_state_d;
      pulse_cnt_q <= pulse_cnt_d;
      val_q       <= val_d;
      vend_q      <= vend_d;
      coin_out_q  <= (rf_state_d == RF_PULSE_HI);
      busy_q      <= (rf_state_d != RF_IDLE);
    end
  end

  assign bus.val_tot     = val_q;
  assign bus.vend_done   = vend_q;
  assign bus.coin_out    = coin_out_q;
  assign bus.refund_busy = busy_q;

endmodule

// File: tb/tb_vend_payment_unit.sv
// Testbench for vend_payment_unit: a vector table, hand-written multi-cycle
// sequences and randomized traffic checked against a behavioural model.
module tb_vend_payment_unit;

  localparam int TC = 8;
  localparam int CP = 2;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  bit   modelOn;

  vend_payment_unit_if vif ();

  vend_payment_unit #(
    .TIME_CYCLES      (TC),
    .COIN_PULSE_CYCLES(CP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       coin;
    logic [1:0] cv;
    logic       rel;
    logic       back;
    int         expVal;
    logic       expVend;
    logic       expExb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input int st, input int coin, input int cv, input int rel,
                                 input int back, input int val, input int vend, input int exb);
    vec_t v;
    v.st = 3'(st); v.coin = 1'(coin); v.cv = 2'(cv); v.rel = 1'(rel); v.back = 1'(back);
    v.expVal = val; v.expVend = 1'(vend); v.expExb = 1'(exb);
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    vif.state_now       = v.st;
    vif.coin_in         = v.coin;
    vif.coin_val        = v.cv;
    vif.release_product = v.rel;
    vif.back_money      = v.back;
    tick();
  endtask

  // Behavioural reference: credit as an integer, a refund as a cycle index
  // into a 2*CP*N long pulse train, the timer as the age of the current state.
  int   mCredit, mN, mK, mAge;
  bit   mRefunding, mVend, mExb;
  logic [2:0] mPrevState;
  bit   mPrevCoin, mPrevRel, mPrevBack;
  bit   mCoinOut;

  always @(posedge clk or negedge rst) begin
    bit coinEdge, relEdge, backEdge, changed, entryZzz, busy, start;
    if (!rst) begin
      mCredit = 0; mN = 0; mK = 0; mAge = 0;
      mRefunding = 0; mVend = 0; mExb = 0;
      mPrevState = 3'd0; mPrevCoin = 0; mPrevRel = 0; mPrevBack = 0;
    end else begin
      coinEdge = vif.coin_in && !mPrevCoin;
      relEdge  = vif.release_product && !mPrevRel;
      backEdge = vif.back_money && !mPrevBack;
      changed  = (vif.state_now != mPrevState);
      entryZzz = (vif.state_now == 3'd0) && (mPrevState != 3'd0);
      if (changed || vif.state_now == 3'd0) mAge = 0;
      else mAge++;
      mExb  = !changed && (vif.state_now != 3'd0) && (mAge != 0) && (mAge % TC == 0);
      busy  = mRefunding;
      start = !busy && (mCredit != 0) && (backEdge || entryZzz);
      mVend = 0;
      if (busy) begin
        mK++;
        mCredit = mN - (mK + CP) / (2 * CP);
        if (mK == 2 * CP * mN) mRefunding = 0;
      end else begin
        if (relEdge && !backEdge && !start) begin
          mCredit = 0;
          mVend   = 1;
        end else if (coinEdge && vif.state_now == 3'd2) begin
          mCredit = mCredit + int'(vif.coin_val);
          if (mCredit > 15) mCredit = 15;
        end
        if (start) begin
          mRefunding = 1;
          mN = mCredit;
          mK = 0;
        end
      end
      mPrevState = vif.state_now;
      mPrevCoin  = vif.coin_in;
      mPrevRel   = vif.release_product;
      mPrevBack  = vif.back_money;
    end
    mCoinOut = mRefunding && ((mK % (2 * CP)) < CP);
  end

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (modelOn && rst) begin
      checkOutput("model val_tot", vif.val_tot, mCredit);
      checkOutput("model coin_out", vif.coin_out, mCoinOut);
      checkOutput("model refund_busy", vif.refund_busy, mRefunding);
      checkOutput("model vend_done", vif.vend_done, mVend);
      checkOutput("model time_max_exb", vif.time_max_exb, mExb);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0; modelOn = 0;
    rst = 1'b1;
    vif.state_now = 3'd0; vif.coin_in = 0; vif.coin_val = 0;
    vif.release_product = 0; vif.back_money = 0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset val_tot", vif.val_tot, 0);
    checkOutput("reset coin_out", vif.coin_out, 0);
    checkOutput("reset refund_busy", vif.refund_busy, 0);
    checkOutput("reset vend_done", vif.vend_done, 0);
    checkOutput("reset time_max_exb", vif.time_max_exb, 0);
    rst = 1'b1;
    modelOn = 1;

    // Credit accumulation, edge-only coins, wrong-state coin, release, saturation.
    vecs.push_back(mkVec(2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(2, 1, 2, 0, 0, 2, 0, 0));
    vecs.push_back(mkVec(2, 0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mkVec(2, 1, 1, 0, 0, 3, 0, 0));
    vecs.push_back(mkVec(2, 1, 3, 0, 0, 3, 0, 0));
    vecs.push_back(mkVec(2, 0, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mkVec(2, 1, 3, 0, 0, 6, 0, 0));
    vecs.push_back(mkVec(2, 0, 0, 0, 0, 6, 0, 0));
    vecs.push_back(mkVec(2, 0, 0, 0, 0, 6, 0, 1));
    vecs.push_back(mkVec(1, 1, 3, 0, 0, 6, 0, 0));
    vecs.push_back(mkVec(1, 0, 0, 0, 0, 6, 0, 0));
    vecs.push_back(mkVec(3, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mkVec(3, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkVec(2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(2, 1, 3, 0, 0, 3, 0, 0));
    vecs.push_back(mkVec(2, 0, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mkVec(2, 1, 3, 0, 0, 6, 0, 0));
    vecs.push_back(mkVec(2, 0, 0, 0, 0, 6, 0, 0));
    vecs.push_back(mkVec(2, 1, 3, 0, 0, 9, 0, 0));
    vecs.push_back(mkVec(2, 0, 0, 0, 0, 9, 0, 0));
    vecs.push_back(mkVec(2, 1, 3, 0, 0, 12, 0, 0));
    vecs.push_back(mkVec(2, 0, 0, 0, 0, 12, 0, 1));
    vecs.push_back(mkVec(2, 1, 3, 0, 0, 15, 0, 0));
    vecs.push_back(mkVec(2, 0, 0, 0, 0, 15, 0, 0));
    vecs.push_back(mkVec(2, 1, 2, 0, 0, 15, 0, 0));
    vecs.push_back(mkVec(2, 0, 0, 0, 0, 15, 0, 0));
    vecs.push_back(mkVec(2, 1, 0, 0, 0, 15, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d val_tot", i), vif.val_tot, vecs[i].expVal);
      checkOutput($sformatf("vec%0d vend_done", i), vif.vend_done, vecs[i].expVend);
      checkOutput($sformatf("vec%0d time_max_exb", i), vif.time_max_exb, vecs[i].expExb);
      checkOutput($sformatf("vec%0d refund_busy", i), vif.refund_busy, 0);
    end

    // Refund of 3 units with back_money held high.
    vif.coin_in = 0; vif.release_product = 1;
    tick();
    checkOutput("sale clear val_tot", vif.val_tot, 0);
    vif.coin_in = 1; vif.coin_val = 3;
    tick();
    vif.coin_in = 0;
    tick();
    checkOutput("refund3 preload", vif.val_tot, 3);
    vif.back_money = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      checkOutput($sformatf("refund3 k%0d coin_out", k), vif.coin_out, ((k % 4) < 2) ? 1 : 0);
      checkOutput($sformatf("refund3 k%0d busy", k), vif.refund_busy, 1);
      checkOutput($sformatf("refund3 k%0d val_tot", k), vif.val_tot, 3 - (k + 2) / 4);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("refund3 done busy", vif.refund_busy, 0);
      checkOutput("refund3 done coin_out", vif.coin_out, 0);
      checkOutput("refund3 done val_tot", vif.val_tot, 0);
    end
    vif.back_money = 0;

    // Sale of 5 units, then return to 000 must not refund.
    vif.release_product = 0; vif.coin_in = 1; vif.coin_val = 3;
    tick();
    vif.coin_in = 0;
    tick();
    vif.coin_in = 1; vif.coin_val = 2;
    tick();
    checkOutput("sale preload", vif.val_tot, 5);
    vif.coin_in = 0; vif.release_product = 1;
    tick();
    checkOutput("sale val_tot", vif.val_tot, 0);
    checkOutput("sale vend_done", vif.vend_done, 1);
    tick();
    checkOutput("sale vend_done width", vif.vend_done, 0);
    vif.state_now = 3'd3;
    tick();
    vif.state_now = 3'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("sale no refund busy", vif.refund_busy, 0);
      checkOutput("sale no refund coin_out", vif.coin_out, 0);
    end
    vif.release_product = 0;

    // State change at count 5 restarts the window.
    vif.state_now = 3'd2;
    tick();
    repeat (5) tick();
    vif.state_now = 3'd1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput($sformatf("restart exb step%0d", i), vif.time_max_exb, (i == 8) ? 1 : 0);
    end

    // Reset in the middle of a 4-unit refund.
    vif.state_now = 3'd2;
    tick();
    vif.coin_in = 1; vif.coin_val = 2;
    tick();
    vif.coin_in = 0;
    tick();
    vif.coin_in = 1;
    tick();
    checkOutput("refund4 preload", vif.val_tot, 4);
    vif.coin_in = 0; vif.back_money = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("refund4 k%0d coin_out", k), vif.coin_out, ((k % 4) < 2) ? 1 : 0);
    end
    rst = 1'b0;
    #1;
    checkOutput("midreset val_tot", vif.val_tot, 0);
    checkOutput("midreset coin_out", vif.coin_out, 0);
    checkOutput("midreset refund_busy", vif.refund_busy, 0);
    checkOutput("midreset vend_done", vif.vend_done, 0);
    checkOutput("midreset time_max_exb", vif.time_max_exb, 0);
    vif.back_money = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("postreset val_tot", vif.val_tot, 0);
    checkOutput("postreset busy", vif.refund_busy, 0);
    checkOutput("postreset coin_out", vif.coin_out, 0);

    // Auto-refund of stranded credit on entry to 000.
    vif.coin_in = 1; vif.coin_val = 2;
    tick();
    vif.coin_in = 0;
    tick();
    checkOutput("auto preload", vif.val_tot, 2);
    vif.state_now = 3'd0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("auto k%0d coin_out", k), vif.coin_out, ((k % 4) < 2) ? 1 : 0);
      checkOutput($sformatf("auto k%0d busy", k), vif.refund_busy, 1);
      checkOutput($sformatf("auto k%0d val_tot", k), vif.val_tot, 2 - (k + 2) / 4);
    end
    tick();
    checkOutput("auto done busy", vif.refund_busy, 0);
    checkOutput("auto done val_tot", vif.val_tot, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int r;
      if ($urandom_range(0, 15) == 0) begin
        r = int'($urandom_range(0, 9));
        vif.state_now = (r < 5) ? 3'd2 : 3'(r % 6);
      end
      if ($urandom_range(0, 2) == 0) vif.coin_in = ~vif.coin_in;
      vif.coin_val = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) vif.release_product = ~vif.release_product;
      if ($urandom_range(0, 19) == 0) vif.back_money = ~vif.back_money;
      tick();
    end

    modelOn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vend_payment_unit.md
# vend_payment_unit

Payment-side counterpart of the vending controller FSM. It produces the controller's `val_tot` credit and `time_max_exb` window pulses, and it acts on the controller's `release_product` and `back_money` outputs. On refund it pays coins back as paced `coin_out` pulses; on release it clears the credit. It sits between the coin acceptor/ejector hardware and the controller, and observes the controller's `state_now`.

## Interface

Parameters:
- `TIME_CYCLES`, default 50000000: clock cycles per exhibition window (one `time_max_exb` pulse per window).
- `COIN_PULSE_CYCLES`, default 4: cycles `coin_out` stays high, and then low, per refunded unit.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `state_now` in 3: controller state, encoded as zzz=000, validate_id=001, validate_coin=010, all_ok=011, error1=100, error2=101.
- `coin_in` in 1: coin sensor level, already synchronous to `clk`.
- `coin_val` in 2: value in units of the coin present while `coin_in` is high.
- `release_product` in 1: controller level; only the rising edge is acted on.
- `back_money` in 1: controller level; only the rising edge is acted on.
- `val_tot` out 4: accumulated credit in units.
- `time_max_exb` out 1: one-cycle window-expiry pulse.
- `coin_out` out 1: ejector drive, one high pulse per refunded unit.
- `refund_busy` out 1: high while a refund is in progress.
- `vend_done` out 1: one-cycle pulse when a sale is committed.

## Operation

- **Reset:** all outputs are 0, all counters are 0 and the refund FSM is IDLE. A reset mid-refund abandons the units not yet paid.
- **Edge detection:** registered copies of `coin_in`, `release_product`, `back_money` and `state_now`. Edge = current AND NOT previous. The controller holds `back_money`/`release_product` high until its own reset, so levels must never be acted on.
- **Timer:**
  - Counter runs while `state_now` != 000 and holds at 0 in 000.
  - Any change of `state_now` (current != registered) reloads the counter to 0.
  - On count == TIME_CYCLES-1: `time_max_exb`=1 for one cycle, and the counter wraps to 0.
- **Credit:**
  - A `coin_in` rising edge while `state_now`==010 adds `coin_val` to `val_tot`.
  - The sum saturates at 15; `coin_val`=0 adds nothing.
  - Coin edges in any other state are ignored; the hardware returns those coins mechanically.
- **Release:** a `release_product` rising edge sets `val_tot` to 0 and pulses `vend_done` for one cycle. This is ignored if `refund_busy`.
- **Refund FSM (states IDLE, PULSE_HI, PULSE_LO):**
  - IDLE → PULSE_HI on a `back_money` rising edge with `val_tot` != 0.
  - IDLE → PULSE_HI on entry to `state_now`==000 with `val_tot` != 0 (auto-refund of stranded credit).
  - In either case, the `back_money` edge with `val_tot`==0 is a no-op.
  - PULSE_HI: `coin_out`=1 for COIN_PULSE_CYCLES cycles, then → PULSE_LO with `val_tot` decremented by 1.
  - PULSE_LO: `coin_out`=0 for COIN_PULSE_CYCLES cycles, then → PULSE_HI if `val_tot` != 0, else → IDLE.
  - `refund_busy` = (state != IDLE).
- **Simultaneous events:**
  - Coin edges are ignored while `refund_busy`, even in state 010.
  - If a release edge and a refund edge occur in the same cycle, refund wins; `vend_done` is not pulsed.

## Timing

- `val_tot` shows the new credit in the cycle after the edge where the coin rising edge is sampled (1-cycle latency).
- `time_max_exb` first fires exactly TIME_CYCLES cycles after a `state_now` change, then every TIME_CYCLES cycles while the state is unchanged.
- A refund of N units takes 2·COIN_PULSE_CYCLES·N cycles. `coin_out` rises 1 cycle after the triggering edge is sampled.
- `refund_busy` falls in the same cycle PULSE_LO exits with `val_tot`==0.
- `vend_done` and the clear of `val_tot` occur 1 cycle after the release edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure

- Shared package holds the controller state encodings (ST_ZZZ..ST_ERROR2, 3-bit) used by both this block and the controller, plus the refund FSM encodings.
- One sub-module, `exb_timer`:
  - Parameter TIME_CYCLES.
  - Inputs: `clk`, `rst`, enable, restart.
  - Output: `time_max_exb` pulse.
- Credit, edge detection and the refund FSM live in the top module.

## Test plan

All scenarios use TIME_CYCLES=8 and COIN_PULSE_CYCLES=2.

1. Reset, then `state_now`=010 with coins of value 2, 1, 3 → `val_tot` goes 2, 3, 6, each one cycle after its edge; `time_max_exb` pulses every 8 cycles.
2. `state_now`=010, 9 coins of value 2 → `val_tot` saturates at 15. A coin presented with `state_now`=001 leaves `val_tot` unchanged.
3. `val_tot`=3, `back_money` rises and stays high → 3 `coin_out` pulses of 2 high/2 low cycles, `refund_busy` high for 12 cycles, `val_tot` ends at 0, no second refund.
4. `val_tot`=5, `release_product` rises → `val_tot`=0 and a one-cycle `vend_done`; `state_now` 011→000 then produces no refund.
5. `state_now` change at count 5 → counter restarts; `time_max_exb` appears 8 cycles after the change, not 3.
6. Refund of 4 units with `rst` asserted after the 2nd pulse → all outputs go to 0 immediately; after release, `val_tot`=0 and the FSM is IDLE. Separately, `val_tot`=2 with entry into 000 → auto-refund of 2 pulses.
